dm_be_ctrl: RTL and testbench
=============================

# dm_be_ctrl

Parametrised byte-enabled data memory for the MEM stage. It handles word, half and byte loads and stores, with sign or zero extension on loads. It detects misaligned and out-of-range accesses and reports them as MIPS AdEL/AdES exception codes. After reset it runs a counter-driven clear sequence and holds off requests with `ready` low until the array is zeroed.

## Interface
Parameters:
- `ADDR_W`, default 12: word-address bits. Depth is 2^ADDR_W words.
- `BASE`, default 32'h0000_0000: byte address of word 0. Must be word-aligned.

Ports:
- `clk`, input, 1: clock.
- `rst`, input, 1: reset, synchronous, active-high.
- `req`, input, 1: access request. Sampled only when `ready`=1.
- `op`, input, 4: access type (`DM_NONE`, `DM_LW`, `DM_LH`, `DM_LHU`, `DM_LB`, `DM_LBU`, `DM_SW`, `DM_SH`, `DM_SB`).
- `addr`, input, 32: byte address.
- `wdata`, input, 32: store data, right-aligned (low byte/half is used).
- `pc`, input, 32: PC of the MEM-stage instruction. Used for trace only.
- `ready`, output, 1: 1 when the clear sequence is done.
- `be`, output, 4: byte enables of the current request. Combinational.
- `exc`, output, 1: current request faults. Combinational, same cycle as `req`.
- `excode`, output, 5: 4 (AdEL) for a load fault, 5 (AdES) for a store fault, 0 otherwise.
- `rvalid`, output, 1: load data is valid. Registered.
- `rdata`, output, 32: extended load data. Registered.

## Operation
- An access is accepted when `req & ready & op!=DM_NONE`.
- Offset is `off = addr - BASE`.
- Range fault: `addr < BASE` or `off >= 4·2^ADDR_W`.
- Alignment fault:
  - LW/SW with `addr[1:0]!=0`.
  - LH/LHU/SH with `addr[0]!=0`.
  - Byte accesses never fault on alignment.
- `exc` = accepted & (range fault | alignment fault).
- `be`:
  - Word: 1111.
  - Half: 0011 when `addr[1]`=0, 1100 when `addr[1]`=1.
  - Byte: one-hot of `addr[1:0]` (00→0001, 01→0010, 10→0100, 11→1000).
  - `be`=0000 when `exc`=1, when the op is a load, or when no access is accepted.
- Stores: at the clock edge, write the lanes with `be`=1 at word `off[ADDR_W+1:2]`. The other lanes keep their value. A faulting store writes nothing.
- Loads: read word `off[ADDR_W+1:2]`, select the lane(s), then extend.
  - LB/LH sign-extend.
  - LBU/LHU zero-extend.
  - LW passes the word through.
- Faulting load: `rvalid` stays 0 and `rdata` holds its previous value.
- State machine:
  - CLEAR: entered on `rst` from any state. A counter walks every word, writing 0 at one word per cycle. `ready`=0.
  - CLEAR → IDLE after the counter writes word 2^ADDR_W−1.
  - IDLE: `ready`=1 and accesses are serviced. No other states.
- `rst` asserted mid-CLEAR restarts the counter at 0.
- `rst` asserted in IDLE aborts any in-flight load: `rvalid`=0 next cycle.

## Timing
- Reset values (cycle after `rst`): `ready`=0, `rvalid`=0, `rdata`=0, FSM=CLEAR, counter=0.
- `be`, `exc`, `excode` are combinational: 0 while `ready`=0.
- Clear takes exactly 2^ADDR_W cycles after `rst` deasserts. `ready` rises on the next cycle.
- Load latency is 1 cycle: request at edge n, then `rvalid`=1 and `rdata` valid after edge n+1 for one cycle.
- One access per cycle, back-to-back allowed.
- Store at edge n, load of the same word at edge n+1: returns the stored data (the write completes first).
- Load and store never coincide (single `op`).

## Configuration
- `DM_TRACE_EN` defined: each successful store prints `"%d@%h: *%h <= %h"` with `$time`, `pc`, the word-aligned byte address, and the full merged 32-bit word after the write. Faulting stores and clear writes print nothing.
- `DM_TRACE_EN` undefined: no `$display`. `pc` is unused.

## Structure
- Shared package `dm_pkg`:
  - `op` encodings: `DM_NONE`=0, `DM_LW`=1, `DM_LH`=2, `DM_LHU`=3, `DM_LB`=4, `DM_LBU`=5, `DM_SW`=6, `DM_SH`=7, `DM_SB`=8.
  - Exception codes `EXC_ADEL`=4, `EXC_ADES`=5.
  - FSM state constants.
- One sub-module `dm_load_ext`: combinational lane select plus sign/zero extension, taking word, `addr[1:0]` and `op`.

## Test plan
- Reset and clear, with ADDR_W=4: assert `rst` for 1 cycle → `ready`=0 for 16 cycles, then 1. LW of every word returns 0.
- Byte/half stores:
  - SW 0x0 ← 0x11223344.
  - SB 0x1 ← 0xAA → word 0x1122AA44, `be`=0010.
  - SH 0x2 ← 0xBEEF → word 0xBEEFAA44, `be`=1100.
- Load extension with word 0x80FF7F01 at 0x4:
  - LB 0x6 → 0xFFFFFFFF.
  - LBU 0x6 → 0x000000FF.
  - LH 0x6 → 0xFFFF80FF.
  - LHU 0x4 → 0x00007F01.
  - Each result arrives one cycle after the request.
- Exceptions:
  - LW 0x2 → `exc`=1, `excode`=4, `rvalid`=0.
  - SH 0x5 → `excode`=5, memory unchanged.
  - SW 0x40 with ADDR_W=4 → `excode`=5.
- Back-to-back SW 0x8 ← 0xCAFEBABE then LW 0x8 on the next cycle → `rdata`=0xCAFEBABE.
- `rst` during clear at cycle 7 → the counter restarts at 0. `ready` rises 16 cycles after `rst` deasserts.

Source files
------------

// File: rtl/dm_pkg.sv
// Shared definitions for the byte-enabled data memory: access encodings,
// MIPS address-error exception codes and controller state constants.
package dm_pkg;

    typedef enum logic [3:0] {
        DM_NONE = 4'd0,
        DM_LW   = 4'd1,
        DM_LH   = 4'd2,
        DM_LHU  = 4'd3,
        DM_LB   = 4'd4,
        DM_LBU  = 4'd5,
        DM_SW   = 4'd6,
        DM_SH   = 4'd7,
        DM_SB   = 4'd8
    } dm_op_e;

    localparam logic [4:0] EXC_NONE = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } dm_state_e;

    function automatic logic op_is_load(input logic [3:0] op);
        return (op == DM_LW) || (op == DM_LH) || (op == DM_LHU) ||
               (op == DM_LB) || (op == DM_LBU);
    endfunction

    function automatic logic op_is_store(input logic [3:0] op);
        return (op == DM_SW) || (op == DM_SH) || (op == DM_SB);
    endfunction

endpackage

// File: rtl/dm_load_ext.sv
// Load lane select and sign/zero extension: picks the byte or half addressed
// by lane out of a memory word and widens it to 32 bits.
module dm_load_ext
    import dm_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  lane,
    input  logic [3:0]  op,
    output logic [31:0] data
);

    logic [15:0] half;
    logic [7:0]  byte_sel;

    assign half     = lane[1] ? word[31:16] : word[15:0];
    assign byte_sel = word[8*lane +: 8];

    // NOTE: data gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        data = word;
        case (op)
            DM_LH:   data = {{16{half[15]}}, half};
            DM_LHU:  data = {16'h0000, half};
            DM_LB:   data = {{24{byte_sel[7]}}, byte_sel};
            DM_LBU:  data = {24'h000000, byte_sel};
            default: data = word;
        endcase
    end

endmodule

// File: rtl/dm_be_ctrl.sv
// Byte-enabled MEM-stage data memory with AdEL/AdES detection and a
// post-reset clear sequence. Define DM_TRACE_EN to print every committed store.
module dm_be_ctrl
    import dm_pkg::*;
#(
    parameter int          ADDR_W = 12,
    parameter logic [31:0] BASE   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic [3:0]  op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [31:0] pc,
    output logic        ready,
    output logic [3:0]  be,
    output logic        exc,
    output logic [4:0]  excode,
    output logic        rvalid,
    output logic [31:0] rdata
);

    localparam int          DEPTH = 1 << ADDR_W;
    localparam logic [32:0] SPAN  = 33'(DEPTH) << 2;

    // NOTE: the array has no reset; the CLEAR sequence zeroes it one word per cycle instead.
    logic [31:0] mem [DEPTH];

    dm_state_e           state_q, state_d;
    logic [ADDR_W-1:0]   cnt;

    logic [31:0]         off;
    logic [ADDR_W-1:0]   widx;
    logic                is_ld, is_st, acc;
    logic                range_flt, align_flt;
    logic [3:0]          be_raw;
    logic [31:0]         rd_word, wlanes, merged, ld_data;

    assign is_ld = op_is_load(op);
    assign is_st = op_is_store(op);
    assign acc   = req & ready & (is_ld | is_st);

    assign off       = addr - BASE;
    assign widx      = off[ADDR_W+1:2];
    assign range_flt = (addr < BASE) || ({1'b0, off} >= SPAN);

    always_comb begin
        align_flt = 1'b0;
        be_raw    = 4'b0000;
        wlanes    = wdata;
        case (op)
            DM_LW, DM_SW: begin
                align_flt = (addr[1:0] != 2'b00);
                be_raw    = 4'b1111;
            end
            DM_LH, DM_LHU, DM_SH: begin
                align_flt = addr[0];
                be_raw    = addr[1] ? 4'b1100 : 4'b0011;
                wlanes    = {2{wdata[15:0]}};
            end
            DM_LB, DM_LBU, DM_SB: begin
                be_raw    = 4'b0001 << addr[1:0];
                wlanes    = {4{wdata[7:0]}};
            end
            default: ;
        endcase
    end

    assign exc    = acc & (range_flt | align_flt);
    assign excode = !exc ? EXC_NONE : (is_st ? EXC_ADES : EXC_ADEL);
    assign be     = (acc & is_st & !exc) ? be_raw : 4'b0000;

    assign rd_word = mem[widx];

    // Lanes not enabled keep the stored byte; this is also the traced word.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            merged[8*i +: 8] = be[i] ? wlanes[8*i +: 8] : rd_word[8*i +: 8];
        end
    end

    dm_load_ext u_load_ext (
        .word (rd_word),
        .lane (addr[1:0]),
        .op   (op),
        .data (ld_data)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_CLEAR;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_CLEAR: if (cnt == '1) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    assign ready = (state_q == ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst)                        cnt <= '0;
        else if (state_q == ST_CLEAR)   cnt <= cnt + ADDR_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == ST_CLEAR) begin
                mem[cnt] <= '0;
            end else if (be != 4'b0000) begin
                mem[widx] <= merged;
`ifdef DM_TRACE_EN
                $display("%d@%h: *%h <= %h", $time, pc, {addr[31:2], 2'b00}, merged);
`endif
            end
        end
    end

`ifndef DM_TRACE_EN
    logic unused_pc;
    assign unused_pc = ^pc;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid <= 1'b0;
            rdata  <= '0;
        end else begin
            rvalid <= acc & is_ld & !exc;
            if (acc & is_ld & !exc) rdata <= ld_data;
        end
    end

endmodule

// File: tb/tb_dm_be_ctrl.sv
// Scoreboard bench for dm_be_ctrl with ADDR_W=4: directed accesses push
// expected load results; a negedge monitor pops and checks data and latency.
module tb_dm_be_ctrl;
    import dm_pkg::*;

    localparam int ADDR_W = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic [3:0]  op = DM_NONE;
    logic [31:0] addr = '0, wdata = '0, pc = '0;
    logic        ready, exc, rvalid;
    logic [3:0]  be;
    logic [4:0]  excode;
    logic [31:0] rdata;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;
    exp_t sb[$];

    dm_be_ctrl #(.ADDR_W(ADDR_W), .BASE(32'h0000_0000)) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .op     (op),
        .addr   (addr),
        .wdata  (wdata),
        .pc     (pc),
        .ready  (ready),
        .be     (be),
        .exc    (exc),
        .excode (excode),
        .rvalid (rvalid),
        .rdata  (rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every rvalid must match the oldest expected load, on its due cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rvalid !== 1'b0) begin
                if (sb.size() == 0) begin
                    check("unexpected_rvalid", 32'(rvalid), 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("rdata", rdata, e.data);
                    check("latency", 32'(cyc), 32'(e.due));
                end
            end
        end
    end

    task automatic access(input string name, input dm_op_e o, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] exp_be,
                          input logic [4:0] exp_code, input logic [31:0] exp_rd);
        @(negedge clk);
        req = 1'b1; op = o; addr = a; wdata = d; pc = pc + 32'd4;
        #1;
        check({name, "_be"}, 32'(be), 32'(exp_be));
        check({name, "_exc"}, 32'(exc), 32'(exp_code != 5'd0));
        check({name, "_excode"}, 32'(excode), 32'(exp_code));
        if (op_is_load(o) && exp_code == 5'd0) sb.push_back('{exp_rd, cyc + 1});
    endtask

    task automatic idle();
        @(negedge clk);
        req = 1'b0; op = DM_NONE;
    endtask

    task automatic wait_ready(input string name, input int exp_n);
        int n = 0;
        while (ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(n), 32'(exp_n));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        // A store is held on the inputs through reset and clear; it must be ignored.
        req = 1'b1; op = DM_SW; addr = 32'h0; wdata = 32'hFFFF_FFFF;
        @(negedge clk);
        @(negedge clk);
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_rvalid", 32'(rvalid), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_be", 32'(be), 32'd0);
        check("rst_exc", 32'(exc), 32'd0);
        check("rst_excode", 32'(excode), 32'd0);
        rst = 1'b0;
        wait_ready("clear_cycles", 16);
        req = 1'b0; op = DM_NONE;

        for (int i = 0; i < 16; i++) access("lw_clr", DM_LW, 32'(i * 4), 0, 4'b0000, 0, 32'h0);

        access("sw0", DM_SW, 32'h0, 32'h1122_3344, 4'b1111, 0, 0);
        access("sb1", DM_SB, 32'h1, 32'h0000_00AA, 4'b0010, 0, 0);
        access("lw0a", DM_LW, 32'h0, 0, 4'b0000, 0, 32'h1122_AA44);
        access("sh2", DM_SH, 32'h2, 32'h0000_BEEF, 4'b1100, 0, 0);
        access("lw0b", DM_LW, 32'h0, 0, 4'b0000, 0, 32'hBEEF_AA44);

        access("sw4", DM_SW, 32'h4, 32'h80FF_7F01, 4'b1111, 0, 0);
        access("lb6", DM_LB, 32'h6, 0, 4'b0000, 0, 32'hFFFF_FFFF);
        access("lbu6", DM_LBU, 32'h6, 0, 4'b0000, 0, 32'h0000_00FF);
        access("lh6", DM_LH, 32'h6, 0, 4'b0000, 0, 32'hFFFF_80FF);
        access("lb5", DM_LB, 32'h5, 0, 4'b0000, 0, 32'h0000_007F);
        access("lb7", DM_LB, 32'h7, 0, 4'b0000, 0, 32'hFFFF_FF80);
        access("lh4", DM_LH, 32'h4, 0, 4'b0000, 0, 32'h0000_7F01);
        access("lhu4", DM_LHU, 32'h4, 0, 4'b0000, 0, 32'h0000_7F01);

        access("lw2_misal", DM_LW, 32'h2, 0, 4'b0000, EXC_ADEL, 0);
        idle();
        check("fault_rvalid", 32'(rvalid), 32'd0);
        check("fault_rdata_hold", rdata, 32'h0000_7F01);

        access("sh5_misal", DM_SH, 32'h5, 32'h0000_DEAD, 4'b0000, EXC_ADES, 0);
        access("lw4_kept", DM_LW, 32'h4, 0, 4'b0000, 0, 32'h80FF_7F01);
        access("sw40_range", DM_SW, 32'h40, 32'h5555_5555, 4'b0000, EXC_ADES, 0);
        access("lw0_kept", DM_LW, 32'h0, 0, 4'b0000, 0, 32'hBEEF_AA44);
        access("lb_range", DM_LB, 32'hFFFF_FFFF, 0, 4'b0000, EXC_ADEL, 0);
        access("sw3c", DM_SW, 32'h3C, 32'h1234_5678, 4'b1111, 0, 0);
        access("lw3c", DM_LW, 32'h3C, 0, 4'b0000, 0, 32'h1234_5678);

        access("sw8", DM_SW, 32'h8, 32'hCAFE_BABE, 4'b1111, 0, 0);
        access("lw8a", DM_LW, 32'h8, 0, 4'b0000, 0, 32'hCAFE_BABE);
        access("sbb", DM_SB, 32'hB, 32'h0000_005A, 4'b1000, 0, 0);
        access("sh8", DM_SH, 32'h8, 32'h0000_1234, 4'b0011, 0, 0);
        access("lw8b", DM_LW, 32'h8, 0, 4'b0000, 0, 32'h5AFE_1234);
        access("none", DM_NONE, 32'h8, 0, 4'b0000, 0, 0);
        idle();
        idle();
        check("drain_main", 32'(sb.size()), 32'd0);

        // Reset part-way through the clear must restart it from word 0.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (7) @(negedge clk);
        check("midclear_ready", 32'(ready), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        wait_ready("reclear_cycles", 16);

        access("lw0_clr", DM_LW, 32'h0, 0, 4'b0000, 0, 32'h0);
        access("lw8_clr", DM_LW, 32'h8, 0, 4'b0000, 0, 32'h0);
        access("lw3c_clr", DM_LW, 32'h3C, 0, 4'b0000, 0, 32'h0);
        idle();
        idle();
        check("drain_final", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
